// File: rtl/acc_arb_ctrl_pkg.sv
// Shared types and constants for the two-requester burst accumulator.
// This package holds the controller state encoding and the datapath widths.
package acc_arb_ctrl_pkg;

    localparam int SUM_W  = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/acc_arb_ctrl_acc_8bit.sv
// 8-bit unsigned input accumulator with a 16-bit running sum.
// A synchronous init has priority over the enable.
module acc_8bit
    import acc_arb_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [SUM_W-1:0]  o_sum
);

    logic [SUM_W-1:0] r_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else if (i_init) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + {{(SUM_W-DATA_W){1'b0}}, i_data};
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/acc_arb_ctrl.sv
// Round-robin arbiter between two burst requesters feeding one accumulator.
// Handshake: a beat moves on a rising edge where i_valid[n] & o_ready[n]; a result moves where o_sum_valid & i_sum_ready.
module acc_arb_ctrl
    import acc_arb_ctrl_pkg::*;
#(
    parameter int LEN_W = 4
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_req,
    input  logic [LEN_W-1:0]  i_len0,
    input  logic [LEN_W-1:0]  i_len1,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [1:0]        i_valid,
    output logic [1:0]        o_ready,
    output logic [1:0]        o_gnt,
    output logic [SUM_W-1:0]  o_sum,
    output logic              o_sum_valid,
    output logic              o_sum_id,
    input  logic              i_sum_ready,
    output logic              o_busy,
    output logic [1:0]        o_dbg_state
);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_gnt;
    logic              r_ptr;
    logic [LEN_W-1:0]  r_cnt;
    logic              w_win;
    logic              w_accept;
    logic              w_acc_init;
    logic [DATA_W-1:0] w_data;

    // Pointer only matters on a tie; a lone requester always wins.
    assign w_win    = (i_req == 2'b11) ? r_ptr : i_req[1];
    assign w_accept = (r_state == ST_RUN) && (|(i_valid & r_gnt));
    assign w_data   = r_gnt[1] ? i_data1 : i_data0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_acc_init  = 1'b0;
        o_ready     = 2'b00;
        o_sum_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req != 2'b00) begin
                    w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                w_acc_init = 1'b1;
                w_next     = (r_cnt != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                o_ready = r_gnt;
                if (w_accept && (r_cnt == LEN_W'(1))) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_sum_valid = 1'b1;
                if (i_sum_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt <= 2'b00;
            r_ptr <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req != 2'b00) begin
                        r_gnt <= w_win ? 2'b10 : 2'b01;
                        r_cnt <= w_win ? i_len1 : i_len0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                ST_DONE: begin
                    // Next tie goes to whichever requester was not just served.
                    if (i_sum_ready) begin
                        r_gnt <= 2'b00;
                        r_ptr <= ~r_gnt[1];
                    end
                end
                default: ;
            endcase
        end
    end

    acc_8bit u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_init  (w_acc_init),
        .i_en    (w_accept),
        .i_data  (w_data),
        .o_sum   (o_sum)
    );

    assign o_gnt       = r_gnt;
    assign o_sum_id    = r_gnt[1];
    assign o_busy      = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule
